// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared constants and helpers for the TRNG word packer
//
// Purpose: constant clog2, bit-order encoding and the saturating-increment
// rule shared by the packer and its FIFO.
// Ports: none (package).
package trng_pkg;

  // Bit-order encoding, matching the lsb_first input level.
  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Saturating +1 for a counter of 'width' bits (1..64), carried in 64 bits.
  // The ceiling is 2^width-1; 64'd1 << 64 yields 0, so width 64 also works.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (value == max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/trng_word_packer_if.sv
// rtl/trng_word_packer_if.sv - valid/ready word stream out of the packer
//
// Purpose: groups the output handshake of the packer.
// Signals: m_data  WORD_W  head-of-FIFO word (0 when empty)
//          m_valid 1       word available
//          m_ready 1       consumer accepts m_data
// Modports: master (packer side), slave (consumer side).
interface trng_word_packer_if #(
  parameter int WORD_W = 64
);
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/trng_sync_fifo.sv
// rtl/trng_sync_fifo.sv - first-word-fall-through synchronous word FIFO
//
// Purpose: small FWFT FIFO; push and pop in the same cycle are accepted even
// when full, because the pop frees the slot the push lands in.
// Ports: clk, rst     clock, asynchronous active-high reset
//        push, wdata  write request / data (ignored when full without pop)
//        pop          read request (ignored when empty)
//        rdata        head word, 0 when empty
//        level        words stored (registered)
//        full, empty  decoded from level
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage needs no reset: rdata is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/trng_word_packer.sv
// rtl/trng_word_packer.sv - packs entropy bits into words with FIFO and drop stats
//
// Purpose: shifts raw entropy bits into WORD_W-bit words (MSB- or LSB-first,
// chosen per word), queues completed words in a FWFT FIFO and counts words
// lost to a full FIFO.
// Ports: clk, rst     clock, asynchronous active-high reset
//        bit_in       entropy bit, bit_valid qualifies it
//        lsb_first    bit order, sampled at the first bit of each word
//        flush        discard the partial word (FIFO kept)
//        clr_stats    clear drop_count and overflow
//        m            word stream (master modport: m_data, m_valid, m_ready)
//        fifo_level   words stored
//        drop_count   saturating count of dropped words
//        overflow     sticky drop flag
module trng_word_packer
  import trng_pkg::*;
#(
  parameter int  WORD_W     = 64,
  parameter int  FIFO_DEPTH = 4,
  parameter int  CNT_W      = 16,
  localparam int LVL_W      = clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic                lsb_first,
  input  logic                flush,
  input  logic                clr_stats,
  trng_word_packer_if.master  m,
  output logic [LVL_W-1:0]    fifo_level,
  output logic [CNT_W-1:0]    drop_count,
  output logic                overflow
);

  localparam int BC_W = clog2(WORD_W);

  logic [WORD_W-1:0] asm_reg;
  logic [WORD_W-1:0] asm_next;
  logic [BC_W-1:0]   bit_cnt;
  logic              order_q;
  logic              cur_order;
  logic              last_bit;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              drop;

  // The first bit of a word uses the live lsb_first; later bits use the
  // order latched with that first bit, so mid-word toggles are ignored.
  assign cur_order = (bit_cnt == '0) ? lsb_first : order_q;
  assign asm_next  = (cur_order == ORDER_LSB) ? {bit_in, asm_reg[WORD_W-1:1]}
                                              : {asm_reg[WORD_W-2:0], bit_in};
  assign last_bit  = (bit_cnt == BC_W'(WORD_W - 1));

  // Flush overrides a coincident bit, including the completing one.
  assign push      = bit_valid & ~flush & last_bit;
  assign m.m_valid = ~empty;
  assign pop       = m.m_valid & m.m_ready;
  assign drop      = push & full & ~pop;

  trng_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (asm_next),
    .pop   (pop),
    .rdata (m.m_data),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg <= '0;
      bit_cnt <= '0;
      order_q <= ORDER_MSB;
    end else if (flush) begin
      asm_reg <= '0;
      bit_cnt <= '0;
    end else if (bit_valid) begin
      if (bit_cnt == '0) order_q <= lsb_first;
      if (last_bit) begin
        asm_reg <= '0;
        bit_cnt <= '0;
      end else begin
        asm_reg <= asm_next;
        bit_cnt <= bit_cnt + BC_W'(1);
      end
    end
  end

  // A drop coinciding with clr_stats is counted after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr_stats) begin
      drop_count <= drop ? CNT_W'(1) : '0;
      overflow   <= drop;
    end else if (drop) begin
      drop_count <= CNT_W'(sat_inc(64'(drop_count), CNT_W));
      overflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_word_packer.sv
// tb/tb_trng_word_packer.sv - self-checking bench for trng_word_packer
module tb_trng_word_packer;

  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in, bit_valid, lsb_first, flush, clr_stats;
  logic [1:0]    fifo_level;
  logic [CW-1:0] drop_count;
  logic          overflow;

  trng_word_packer_if #(.WORD_W(W)) m_if ();

  trng_word_packer #(
    .WORD_W     (W),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .lsb_first  (lsb_first),
    .flush      (flush),
    .clr_stats  (clr_stats),
    .m          (m_if.master),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: word queue, bits of the word in progress, stats.
  logic [W-1:0] mq[$];
  bit           mbits[$];
  bit           morder;
  int           mdrops;
  bit           movf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbits.delete();
    morder = 1'b0;
    mdrops = 0;
    movf   = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from pre-edge state and inputs.
  task automatic model_step(input bit b, bv, lf, fl, cs, rdy);
    bit           push_w;
    bit           pop_w;
    bit           drop_w;
    logic [W-1:0] word;
    push_w = 1'b0;
    word   = '0;
    pop_w  = (mq.size() != 0) && rdy;
    if (fl) begin
      mbits.delete();
    end else if (bv) begin
      if (mbits.size() == 0) morder = lf;
      mbits.push_back(b);
      if (mbits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          if (morder) word[i] = mbits[i];
          else        word[W-1-i] = mbits[i];
        end
        push_w = 1'b1;
        mbits.delete();
      end
    end
    drop_w = push_w && (mq.size() == DEPTH) && !pop_w;
    if (pop_w) void'(mq.pop_front());
    if (push_w && !drop_w) mq.push_back(word);
    if (cs) begin
      mdrops = drop_w ? 1 : 0;
      movf   = drop_w;
    end else if (drop_w) begin
      if (mdrops < CMAX) mdrops++;
      movf = 1'b1;
    end
  endtask

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("cmp_valid", 64'(m_if.m_valid), 64'(mq.size() != 0));
      chk("cmp_data",  64'(m_if.m_data),  (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
      chk("cmp_level", 64'(fifo_level),   64'(mq.size()));
      chk("cmp_drops", 64'(drop_count),   64'(mdrops));
      chk("cmp_ovf",   64'(overflow),     64'(movf));
    end
  end

  task automatic cycle(input bit b, bv, lf, fl, cs, rdy);
    bit_in       = b;
    bit_valid    = bv;
    lsb_first    = lf;
    flush        = fl;
    clr_stats    = cs;
    m_if.m_ready = rdy;
    @(posedge clk);
    model_step(b, bv, lf, fl, cs, rdy);
    #1;
  endtask

  // Sends the top n bits of v, most significant first in time.
  task automatic send_bits(input logic [7:0] v, input int n, input bit lf, input bit rdy);
    for (int i = 0; i < n; i++) cycle(v[7-i], 1'b1, lf, 1'b0, 1'b0, rdy);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    rst = 1'b1;
    bit_in = 1'b0; bit_valid = 1'b0; lsb_first = 1'b0;
    flush = 1'b0; clr_stats = 1'b0; m_if.m_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_valid", 64'(m_if.m_valid), 64'd0);
    chk("rst_data",  64'(m_if.m_data),  64'd0);
    chk("rst_level", 64'(fifo_level),   64'd0);
    chk("rst_drops", 64'(drop_count),   64'd0);
    chk("rst_ovf",   64'(overflow),     64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    // MSB-first word, valid for exactly one cycle with m_ready high.
    send_bits(8'hB2, 8, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_data",  64'(m_if.m_data),  64'hB2);
    chk("t1_valid", 64'(m_if.m_valid), 64'd1);
    idle(1'b1);
    @(negedge clk);
    chk("t1_valid_one_cycle", 64'(m_if.m_valid), 64'd0);

    // LSB-first, then a mid-word order toggle that must be ignored.
    send_bits(8'hB2, 8, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_lsb", 64'(m_if.m_data), 64'h4D);
    idle(1'b1);
    send_bits(8'hB2, 3, 1'b1, 1'b1);
    send_bits(8'h90, 5, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_toggle", 64'(m_if.m_data), 64'h4D);
    idle(1'b1);

    // Backpressure with a dropped third word.
    send_bits(8'h11, 8, 1'b0, 1'b0);
    send_bits(8'h22, 8, 1'b0, 1'b0);
    send_bits(8'h33, 8, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_level", 64'(fifo_level), 64'd2);
    chk("t3_drops", 64'(drop_count), 64'd1);
    chk("t3_ovf",   64'(overflow),   64'd1);
    chk("t3_head",  64'(m_if.m_data), 64'h11);
    idle(1'b1);
    @(negedge clk);
    chk("t3_second", 64'(m_if.m_data), 64'h22);
    idle(1'b1);
    @(negedge clk);
    chk("t3_empty", 64'(m_if.m_valid), 64'd0);

    // Full FIFO: pop coincident with completion avoids a drop.
    send_bits(8'h11, 8, 1'b0, 1'b0);
    send_bits(8'h22, 8, 1'b0, 1'b0);
    send_bits(8'h44, 7, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_level", 64'(fifo_level), 64'd2);
    chk("t4_drops", 64'(drop_count), 64'd1);
    chk("t4_head",  64'(m_if.m_data), 64'h22);
    idle(1'b1);
    @(negedge clk);
    chk("t4_next", 64'(m_if.m_data), 64'h44);
    idle(1'b1);

    // Flush of a partial word, then flush racing the final bit.
    send_bits(8'hA5, 5, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_bits(8'hFF, 8, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_ff", 64'(m_if.m_data), 64'hFF);
    idle(1'b1);
    send_bits(8'h00, 7, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_no_push", 64'(m_if.m_valid), 64'd0);
    send_bits(8'h3C, 8, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_after", 64'(m_if.m_data), 64'h3C);
    idle(1'b1);

    // Saturating drop counter, clear racing a drop, async reset mid-word.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 22; k++) send_bits(8'(k * 7 + 1), 8, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_sat",  64'(drop_count), 64'd15);
    chk("t6_ovf",  64'(overflow),   64'd1);
    send_bits(8'h5A, 7, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_clr_drop", 64'(drop_count), 64'd1);
    chk("t6_clr_ovf",  64'(overflow),   64'd1);
    send_bits(8'h80, 3, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_arst_valid", 64'(m_if.m_valid), 64'd0);
    chk("t6_arst_data",  64'(m_if.m_data),  64'd0);
    chk("t6_arst_level", 64'(fifo_level),   64'd0);
    chk("t6_arst_drops", 64'(drop_count),   64'd0);
    chk("t6_arst_ovf",   64'(overflow),     64'd0);
    model_reset();
    bit_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_bits(8'hC3, 8, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_restart", 64'(m_if.m_data), 64'hC3);
    idle(1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 2) == 0);
    end
    idle(1'b1);
    @(negedge clk);
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_word_packer.md
Name: trng_word_packer

Overview:
Parametrised successor to the 64-bit bit collector in the TRNG datapath. It packs raw entropy bits into WORD_W-bit words and buffers them in a small FIFO. Output uses a valid/ready handshake, so the downstream AXI/DMA side can apply backpressure without stalling the entropy source. It adds bit-order selection, a flush of partial words, and overflow statistics.

Parameters:
WORD_W, 64, output word width; legal range 2..256.
FIFO_DEPTH, 4, word FIFO depth; power of two, at least 2.
CNT_W, 16, width of the dropped-word counter.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
bit_in  in  1  entropy bit
bit_valid  in  1  bit_in is valid this cycle
lsb_first  in  1  0: first bit lands in MSB; 1: first bit lands in bit 0
flush  in  1  pulse; discards the partially assembled word
clr_stats  in  1  pulse; clears drop_count and overflow
m_data  out  WORD_W  head-of-FIFO word
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts m_data
fifo_level  out  clog2(FIFO_DEPTH)+1  words currently stored
drop_count  out  CNT_W  words lost to a full FIFO; saturating
overflow  out  1  sticky; set on any drop

Behaviour:
- Reset (async, rst=1): asm_reg=0, bit_cnt=0, FIFO empty, m_data=0, m_valid=0, fifo_level=0, drop_count=0, overflow=0.
- Assembly:
  - Each cycle with bit_valid=1, bit_in is shifted into asm_reg and bit_cnt increments.
  - MSB-first: asm <= {asm[W-2:0], bit_in}. LSB-first: asm <= {bit_in, asm[W-1:1]}.
  - lsb_first is captured when bit_cnt==0 and held for the whole word. Changing it mid-word has no effect until the next word.
- Completion: bit_valid with bit_cnt==WORD_W-1.
  - The completed word (including this bit) is pushed at this edge and bit_cnt wraps to 0.
  - Latency: m_valid rises the cycle after the final bit when the FIFO was empty.
- FIFO: first-word-fall-through.
  - Pop occurs when m_valid & m_ready.
  - m_data and m_valid must hold stable while m_valid=1 and m_ready=0.
  - m_data is 0 when the FIFO is empty.
- Simultaneous push and pop:
  - Always legal, including when full: the pop frees a slot and the push succeeds, so no drop.
  - fifo_level is unchanged.
  - On an empty FIFO the word is written; m_valid rises next cycle.
- Full FIFO with push and no pop:
  - The word is discarded and the FIFO contents are untouched.
  - drop_count increments, saturating at 2^CNT_W-1.
  - overflow is set to 1 and stays set.
- Flush:
  - bit_cnt <= 0 and asm_reg <= 0. FIFO contents are kept.
  - flush with bit_valid in the same cycle: flush wins, the bit is discarded, and no push occurs even if bit_cnt==WORD_W-1.
- clr_stats:
  - Clears drop_count and overflow.
  - If a drop happens in the same cycle: drop_count <= 1 and overflow <= 1.
- fifo_level is registered and matches the post-edge occupancy.
- Reset mid-word or mid-handshake discards everything; there is no partial-word recovery.
- All arithmetic is unsigned. Pointers are clog2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty is decided from the level counter.

Decomposition:
- Package trng_pkg holds:
  - the clog2 constant function;
  - a localparam bit-order encoding (ORDER_MSB=0, ORDER_LSB=1);
  - the shared saturating-increment width rule.
- One sub-module: trng_sync_fifo, parametrised by WIDTH and DEPTH.
  - Ports: push, wdata, pop, rdata, level, full, empty.
  - Behaviour: first-word-fall-through, same-cycle push+pop when full allowed.
- Packer logic and statistics stay in the top module.

Test Plan:
Bench configuration: WORD_W=8, FIFO_DEPTH=2, CNT_W=4.
1. MSB-first: bits 1,0,1,1,0,0,1,0 with m_ready=1 -> m_data=0xB2, m_valid high for exactly 1 cycle, one cycle after the 8th bit.
2. LSB-first: the same bit sequence -> m_data=0x4D; toggling lsb_first after bit 3 leaves the word 0x4D.
3. Backpressure: m_ready=0, push words 0x11 and 0x22, then a third word 0x33 -> fifo_level=2, drop_count=1, overflow=1, and m_data holds 0x11. Raising m_ready yields 0x11 then 0x22.
4. Full FIFO, m_ready=1 exactly on the completion cycle of a new word -> no drop, fifo_level stays 2, output order is preserved.
5. Flush: flush after 5 bits, then 8 bits all 1 -> m_data=0xFF. Flush coincident with the 8th bit -> no word is pushed.
6. Stress 20 drops with CNT_W=4 -> drop_count=15 (saturated); clr_stats coincident with a drop -> drop_count=1, overflow=1. Async rst mid-word -> all outputs 0 immediately, with no clock edge needed.
